// File: rtl/message_word32_sender.sv
`default_nettype none
// ============================================================================
// Module      : message_word32_sender
// Description : Frames a 16-bit message ID and a 32-bit data word into an
//               11-byte message and feeds it byte by byte to a UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
module message_word32_sender #(
  parameter logic [15:0] SYNC = 16'h1234
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Send,
  input  logic [15:0] MsgID,
  input  logic [31:0] DataWord,
  input  logic        TxReady,
  output logic [7:0]  TxByte,
  output logic        TxLoad,
  output logic        Busy,
  output logic        Done
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LOAD   = 3'd1;
  localparam logic [2:0] c_HOLD   = 3'd2;
  localparam logic [2:0] c_FINISH = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;
  localparam logic [3:0] c_LAST   = 4'd10;

  logic [2:0]  r_state;
  logic [2:0]  w_nextState;
  logic [3:0]  r_index;
  logic [15:0] r_msgId;
  logic [31:0] r_dataWord;
  logic [7:0]  r_checksum;
  logic [7:0]  w_curByte;
  logic        w_indexLegal;

  assign w_indexLegal = (r_index <= c_LAST);

  always_comb begin
    w_curByte = 8'd0;
    case (r_index)
      4'd0:    w_curByte = SYNC[7:0];
      4'd1:    w_curByte = SYNC[15:8];
      4'd2:    w_curByte = 8'h0B;
      4'd3:    w_curByte = 8'h00;
      4'd4:    w_curByte = r_msgId[7:0];
      4'd5:    w_curByte = r_msgId[15:8];
      4'd6:    w_curByte = r_dataWord[7:0];
      4'd7:    w_curByte = r_dataWord[15:8];
      4'd8:    w_curByte = r_dataWord[23:16];
      4'd9:    w_curByte = r_dataWord[31:24];
      4'd10:   w_curByte = r_checksum;
      default: w_curByte = 8'd0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= c_IDLE;
      r_index    <= 4'd0;
      r_msgId    <= 16'd0;
      r_dataWord <= 32'd0;
      r_checksum <= 8'd0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        c_IDLE: begin
          r_index <= 4'd0;
          if (Send) begin
            r_checksum <= 8'd0;
            r_msgId    <= MsgID;
            r_dataWord <= DataWord;
          end
        end
        c_LOAD: begin
          if (w_indexLegal && TxReady) begin
            r_checksum <= r_checksum + w_curByte;
          end
        end
        c_HOLD: begin
          if (r_index < c_LAST) begin
            r_index <= r_index + 4'd1;
          end
        end
        c_FINISH, c_DONE: begin
        end
        // Unreachable encodings fall back to a clean idle index.
        default: r_index <= 4'd0;
      endcase
    end
  end

  always_comb begin
    w_nextState = c_IDLE;
    case (r_state)
      c_IDLE:   w_nextState = Send ? c_LOAD : c_IDLE;
      c_LOAD: begin
        if (!w_indexLegal)  w_nextState = c_IDLE;
        else if (TxReady)   w_nextState = c_HOLD;
        else                w_nextState = c_LOAD;
      end
      c_HOLD: begin
        if (!w_indexLegal)         w_nextState = c_IDLE;
        else if (r_index == c_LAST) w_nextState = c_FINISH;
        else                       w_nextState = c_LOAD;
      end
      c_FINISH: w_nextState = TxReady ? c_DONE : c_FINISH;
      c_DONE:   w_nextState = c_IDLE;
      default:  w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    TxByte = 8'd0;
    TxLoad = 1'b0;
    Busy   = (r_state != c_IDLE);
    Done   = (r_state == c_DONE);
    if (r_state == c_LOAD && w_indexLegal) begin
      TxByte = w_curByte;
      TxLoad = TxReady;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_message_word32_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_message_word32_sender
// Description : Self-checking bench for message_word32_sender (vector table,
//               corner-case sequences and randomized frames vs. a frame model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_message_word32_sender;

  localparam logic [15:0] SYNC = 16'h1234;

  typedef logic [7:0] frame_t [11];
  typedef struct {
    logic [15:0] id;
    logic [31:0] data;
    int          holdoff;
    bit          scramble;
    bit          pulses;
    int          expCsum;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Send;
  logic [15:0] MsgID;
  logic [31:0] DataWord;
  logic        TxReady;
  logic [7:0]  TxByte;
  logic        TxLoad;
  logic        Busy;
  logic        Done;

  int passCnt  = 0;
  int totalCnt = 0;

  message_word32_sender #(.SYNC(SYNC)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Send(Send), .MsgID(MsgID),
    .DataWord(DataWord), .TxReady(TxReady), .TxByte(TxByte),
    .TxLoad(TxLoad), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Frame as a list of little-endian fields followed by the mod-256 sum.
  function automatic frame_t model_frame(input logic [15:0] id, input logic [31:0] data);
    frame_t f;
    logic [79:0] body;
    int sum;
    body = {data, id, 16'd11, SYNC};
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      f[i] = body[8*i +: 8];
      sum += int'(f[i]);
    end
    f[10] = 8'(sum % 256);
    return f;
  endfunction

  // Called just after a negedge with the DUT idle; returns one cycle after Done.
  task automatic run_frame(input logic [15:0] id, input logic [31:0] data, input int holdoff,
                           input bit scramble, input bit pulses, input int expCsum, input string tag);
    frame_t exp;
    logic [7:0] q[$];
    int lowCnt, firstLoad, lastLoad, doneCyc, consecErr, stableErr, busyErr;
    bit prevLoad, waitValid;
    logic [7:0] waitByte;
    exp = model_frame(id, data);
    lowCnt = 0; firstLoad = -1; lastLoad = -10; doneCyc = -1;
    consecErr = 0; stableErr = 0; busyErr = 0; prevLoad = 0; waitValid = 0; waitByte = 8'd0;
    MsgID = id; DataWord = data; Send = 1'b1; TxReady = 1'b1;
    @(posedge Clock);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      #1;
      if (prevLoad && holdoff > 0) lowCnt = holdoff;
      TxReady = (lowCnt == 0);
      if (lowCnt > 0) lowCnt--;
      Send = pulses && ((q.size() == 4 && cyc == lastLoad + 1) ||
                        (q.size() == 11 && (cyc == lastLoad + 1 || cyc == lastLoad + 2)));
      if (scramble) begin
        MsgID = 16'($urandom);
        DataWord = $urandom;
      end
      @(negedge Clock);
      if (!Busy) busyErr++;
      if (holdoff >= 2 && cyc == lastLoad + 2) begin
        waitByte = TxByte;
        waitValid = 1;
      end
      if (TxLoad) begin
        if (prevLoad) consecErr++;
        if (waitValid && TxByte !== waitByte) stableErr++;
        waitValid = 0;
        q.push_back(TxByte);
        if (firstLoad < 0) firstLoad = cyc;
        lastLoad = cyc;
      end
      prevLoad = TxLoad;
      if (Done) begin
        doneCyc = cyc;
        break;
      end
      @(posedge Clock);
    end
    check({tag, " done_seen"}, 32'(doneCyc > 0), 32'd1);
    check({tag, " byte_count"}, q.size(), 32'd11);
    for (int i = 0; i < 11; i++)
      check($sformatf("%s byte%0d", tag, i), (i < q.size()) ? {24'd0, q[i]} : 32'hFFFF_FFFF, {24'd0, exp[i]});
    if (expCsum >= 0)
      check({tag, " checksum"}, (q.size() == 11) ? {24'd0, q[10]} : 32'hFFFF_FFFF, expCsum);
    check({tag, " first_load_cycle"}, firstLoad, 32'd1);
    check({tag, " done_cycle"}, doneCyc, ((lastLoad + holdoff + 1 > lastLoad + 2) ? lastLoad + holdoff + 1 : lastLoad + 2) + 1);
    check({tag, " consecutive_load"}, consecErr, 32'd0);
    check({tag, " byte_stable"}, stableErr, 32'd0);
    check({tag, " busy_in_frame"}, busyErr, 32'd0);
    @(posedge Clock);
    #1; Send = 1'b0; TxReady = 1'b1;
    @(negedge Clock);
    check({tag, " busy_after_done"}, {31'd0, Busy}, 32'd0);
    check({tag, " done_single"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int cnt, errs, doneAt;
    vecs[0] = '{16'h0102, 32'hAABBCCDD, 0,  1'b0, 1'b0, 'h62};
    vecs[1] = '{16'h0102, 32'hAABBCCDD, 20, 1'b0, 1'b0, 'h62};
    vecs[2] = '{16'h0102, 32'hAABBCCDD, 3,  1'b1, 1'b0, 'h62};
    vecs[3] = '{16'hFFFF, 32'hFFFFFFFF, 0,  1'b0, 1'b1, 'h4B};
    vecs[4] = '{16'h0000, 32'h00000000, 1,  1'b0, 1'b0, 'h51};

    Reset_n = 1'b0; Send = 1'b0; MsgID = 16'd0; DataWord = 32'd0; TxReady = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_outputs", {21'd0, TxByte, TxLoad, Busy, Done}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    check("idle_outputs", {21'd0, TxByte, TxLoad, Busy, Done}, 32'd0);

    foreach (vecs[v])
      run_frame(vecs[v].id, vecs[v].data, vecs[v].holdoff, vecs[v].scramble,
                vecs[v].pulses, vecs[v].expCsum, $sformatf("vec%0d", v));

    // Send held high through DONE restarts immediately after the idle cycle.
    Send = 1'b1; MsgID = 16'h0102; DataWord = 32'hAABBCCDD; TxReady = 1'b1;
    doneAt = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clock);
      if (Done) begin doneAt = c; break; end
    end
    check("held_send_done", 32'(doneAt > 0), 32'd1);
    @(negedge Clock);
    check("held_send_idle_gap", {31'd0, Busy}, 32'd0);
    @(negedge Clock);
    check("held_send_restart", {23'd0, TxLoad, TxByte}, {23'd0, 1'b1, 8'h34});
    @(posedge Clock); #1; Send = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clock);
      if (Done) break;
    end
    @(negedge Clock);

    // Reset during byte 6 aborts the frame at once.
    Send = 1'b1; MsgID = 16'h5A5A; DataWord = 32'h12345678; TxReady = 1'b1;
    @(posedge Clock); #1; Send = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 7; c++) begin
      @(negedge Clock);
      if (TxLoad) cnt++;
    end
    check("abort_reached_byte6", cnt, 32'd7);
    Reset_n = 1'b0;
    #1;
    check("abort_outputs_zero", {21'd0, TxByte, TxLoad, Busy, Done}, 32'd0);
    errs = 0;
    repeat (2) begin
      @(negedge Clock);
      if (TxLoad || Done || Busy) errs++;
    end
    Reset_n = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      if (TxLoad || Done || Busy) errs++;
    end
    check("abort_quiet", errs, 32'd0);
    run_frame(16'h0102, 32'hAABBCCDD, 0, 1'b0, 1'b0, 'h62, "after_abort");

    for (int r = 0; r < 6; r++)
      run_frame(16'($urandom), $urandom, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, $sformatf("rand%0d", r));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
`default_nettype wire
